// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Turns mnemonic requests into 32-bit MIPS machine words. Each accepted
// request gets the current pc, which then advances by 4. Encoded words are
// held in a 2-entry {pc, instr} output FIFO.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   request present            in_ready   request can be taken
//   op_sel     mnemonic select            rs/rt/rd   register fields
//   imm        16-bit immediate           target     branch/jump byte address
//   out_valid  FIFO head valid            out_ready  consumer takes the head
//   out_instr  encoded word at head       out_pc     pc of the head word
//   err        one-cycle reject pulse     err_cnt    saturating reject count
// ---------------------------------------------------------------------------
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [31:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] OP_NOP  = 4'd0,  OP_ADDU = 4'd1,  OP_SUBU = 4'd2,
                           OP_JR   = 4'd3,  OP_ORI  = 4'd4,  OP_LW   = 4'd5,
                           OP_SW   = 4'd6,  OP_BEQ  = 4'd7,  OP_LUI  = 4'd8,
                           OP_JAL  = 4'd9,  OP_J    = 4'd10, OP_BNE  = 4'd11,
                           OP_BLEZ = 4'd12, OP_LB   = 4'd13, OP_LH   = 4'd14,
                           OP_LBU  = 4'd15;

    logic [31:0] r_pc;
    logic [1:0]  r_cnt;
    logic [31:0] r_pc0, r_ins0, r_pc1, r_ins1;
    logic        r_err;
    logic [7:0]  r_err_cnt;

    logic [31:0] w_pc_next4;
    logic [31:0] w_br_diff;
    logic        w_br_ok;
    logic        w_j_ok;
    logic [31:0] w_instr;
    logic        w_bad;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    assign w_pc_next4 = r_pc + 32'd4;
    assign w_br_diff  = target - w_pc_next4;
    // Word offset fits signed 16 bits when byte difference bits [31:17]
    // are a pure sign extension.
    assign w_br_ok    = (target[1:0] == 2'b00) &&
                        ((&w_br_diff[31:17]) || (~|w_br_diff[31:17]));
    assign w_j_ok     = (target[1:0] == 2'b00) &&
                        (target[31:28] == w_pc_next4[31:28]);

    always_comb begin
        w_instr = 32'h0000_0000;
        w_bad   = 1'b0;
        case (op_sel)
            OP_NOP:  w_instr = 32'h0000_0000;
            OP_ADDU: w_instr = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
            OP_SUBU: w_instr = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
            OP_JR:   w_instr = {6'b000000, rs, 5'd0, 5'd0, 5'd0, 6'b001000};
            OP_ORI:  w_instr = {6'b001101, rs, rt, imm};
            OP_LUI:  w_instr = {6'b001111, 5'd0, rt, imm};
            OP_LW:   w_instr = {6'b100011, rs, rt, imm};
            OP_SW:   w_instr = {6'b101011, rs, rt, imm};
            OP_LB:   w_instr = {6'b100000, rs, rt, imm};
            OP_LH:   w_instr = {6'b100001, rs, rt, imm};
            OP_LBU:  w_instr = {6'b100100, rs, rt, imm};
            OP_BEQ: begin
                w_instr = {6'b000100, rs, rt, w_br_diff[17:2]};
                w_bad   = ~w_br_ok;
            end
            OP_BNE: begin
                w_instr = {6'b000101, rs, rt, w_br_diff[17:2]};
                w_bad   = ~w_br_ok;
            end
            OP_BLEZ: begin
                w_instr = {6'b000110, rs, 5'd0, w_br_diff[17:2]};
                w_bad   = ~w_br_ok;
            end
            OP_J: begin
                w_instr = {6'b000010, target[27:2]};
                w_bad   = ~w_j_ok;
            end
            OP_JAL: begin
                w_instr = {6'b000011, target[27:2]};
                w_bad   = ~w_j_ok;
            end
            default: w_instr = 32'h0000_0000;
        endcase
    end

    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign out_instr = r_ins0;
    assign out_pc    = r_pc0;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & ~w_bad;
    assign w_pop    = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= 32'h0000_3000;
            r_cnt     <= 2'd0;
            r_pc0     <= 32'h0;
            r_ins0    <= 32'h0;
            r_pc1     <= 32'h0;
            r_ins1    <= 32'h0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_err <= w_accept & w_bad;
            if (w_accept && w_bad && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
            if (w_push)
                r_pc <= w_pc_next4;

            // Head is entry 0. Pushing is impossible when full, so a
            // simultaneous push and pop only happens with one entry.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_pc0  <= r_pc;
                        r_ins0 <= w_instr;
                    end else begin
                        r_pc1  <= r_pc;
                        r_ins1 <= w_instr;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    if (r_cnt == 2'd2) begin
                        r_pc0  <= r_pc1;
                        r_ins0 <= r_ins1;
                    end
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    r_pc0  <= r_pc;
                    r_ins0 <= w_instr;
                end
                default: ;
            endcase
        end
    end

endmodule
